// File: rtl/mult_ctrl_if.sv
// Control bundle between the shift-add multiplier controller and its datapath/user side.
// master = controller (drives enables/selects), slave = datapath and requester.
interface mult_ctrl_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic          start;
    logic          zero;
    logic          lsb_b;
    logic          en_a;
    logic          ld_shift_a;
    logic          en_b;
    logic          ld_shift_b;
    logic          en_p;
    logic          ld_add_p;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter;

    modport master (
        input  start, zero, lsb_b,
        output en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done, iter
    );

    modport slave (
        output start, zero, lsb_b,
        input  en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done, iter
    );
endinterface

// File: rtl/mult_ctrl.sv
// Moore controller for a WIDTH-bit shift-add multiplier datapath.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the datapath reports B == 0.
module mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       clr,
    mult_ctrl_if.master bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SYNC  = 3'd2,
        S_TEST  = 3'd3,
        S_ADD   = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] iter_q, iter_d;
    logic          last_iter;

    assign last_iter = (iter_q == CW'(WIDTH));

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Next state and iteration count; flags are only trusted in TEST,
    // since SYNC gives the datapath one cycle to register them for the new B.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD: begin
                iter_d  = '0;
                state_d = S_SYNC;
            end
            S_SYNC:  state_d = S_TEST;
            S_TEST: begin
`ifdef MULT_EARLY_EXIT_EN
                if (bus.zero)           state_d = S_DONE;
                else if (last_iter)     state_d = S_DONE;
`else
                if (last_iter)          state_d = S_DONE;
`endif
                else if (bus.lsb_b)     state_d = S_ADD;
                else                    state_d = S_SHIFT;
            end
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: begin
                if (!last_iter) iter_d = CW'(iter_q + 1'b1);
                state_d = S_SYNC;
            end
            S_DONE:  state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                iter_d  = '0;
            end
        endcase
    end

`ifndef MULT_EARLY_EXIT_EN
    logic zero_unused;
    assign zero_unused = bus.zero;
`endif

    always_comb begin
        bus.en_a       = 1'b0;
        bus.ld_shift_a = 1'b0;
        bus.en_b       = 1'b0;
        bus.ld_shift_b = 1'b0;
        bus.en_p       = 1'b0;
        bus.ld_add_p   = 1'b0;
        bus.busy       = (state_q != S_IDLE);
        bus.done       = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                bus.en_a = 1'b1;
                bus.en_b = 1'b1;
                bus.en_p = 1'b1;
            end
            S_ADD: begin
                bus.en_p     = 1'b1;
                bus.ld_add_p = 1'b1;
            end
            S_SHIFT: begin
                bus.en_a       = 1'b1;
                bus.ld_shift_a = 1'b1;
                bus.en_b       = 1'b1;
                bus.ld_shift_b = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.iter = iter_q;
endmodule
